// File: rtl/branch_dir_predictor_if.sv
// Fetch-lookup, execute-train and performance-counter signals of the
// bimodal direction predictor.
interface branch_dir_predictor_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned XLEN  = 32
);
    logic [WIDTH-1:0][XLEN-1:0] if_pc;
    logic [WIDTH-1:0]           if_is_br;
    logic [WIDTH-1:0][1:0]      pred_state;
    logic [WIDTH-1:0]           pred_taken;
    logic [WIDTH-1:0]           ex_valid;
    logic [WIDTH-1:0][XLEN-1:0] ex_pc;
    logic [WIDTH-1:0]           ex_taken;
    logic [WIDTH-1:0]           ex_is_jump;
    logic [WIDTH-1:0]           ex_pred_taken;
    logic [WIDTH-1:0]           mispredict;
    logic [31:0]                br_count;
    logic [31:0]                mispred_count;

    modport master (
        output if_pc, if_is_br, ex_valid, ex_pc, ex_taken, ex_is_jump, ex_pred_taken,
        input  pred_state, pred_taken, mispredict, br_count, mispred_count
    );

    modport slave (
        input  if_pc, if_is_br, ex_valid, ex_pc, ex_taken, ex_is_jump, ex_pred_taken,
        output pred_state, pred_taken, mispredict, br_count, mispred_count
    );
endinterface

// File: rtl/branch_dir_predictor.sv
// Bimodal branch-direction predictor: untagged table of 2-bit saturating
// counters, 0-cycle lookup per fetch slot, trained in slot order from Execute.
module branch_dir_predictor #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned BHT_SIZE = 64,
    parameter int unsigned XLEN     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    branch_dir_predictor_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(BHT_SIZE);
    localparam int unsigned CNT_W = 32;
    localparam int unsigned INC_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEA_NT    = 2'b01,
        WEA_T     = 2'b10,
        STRONG_T  = 2'b11
    } state_t;

    state_t           bht_q [BHT_SIZE];
    state_t           bht_d [BHT_SIZE];
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] mis_q;
    logic [INC_W-1:0] n_br;
    logic [INC_W-1:0] n_mis;
    logic             unused_pc_bits;

    function automatic logic [IDX_W-1:0] idx(input logic [XLEN-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic state_t train(input state_t s, input logic taken, input logic jump);
        if (jump)
            return STRONG_T;
        if (taken)
            return (s == STRONG_T) ? STRONG_T : state_t'(2'(s + 2'd1));
        return (s == STRONG_NT) ? STRONG_NT : state_t'(2'(s - 2'd1));
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                  input logic [INC_W-1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, c} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // Only the index bits of each PC select an entry; the rest are don't-care.
    assign unused_pc_bits = ^{bus.if_pc, bus.ex_pc};

    // Lookup reads the registered table only, so Execute never reaches pred_*.
    always_comb begin
        bus.pred_state = '0;
        bus.pred_taken = '0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            bus.pred_state[k] = bht_q[idx(bus.if_pc[k])];
            bus.pred_taken[k] = bus.if_is_br[k] & bus.pred_state[k][1];
        end
    end

    // Jumps are always taken, whatever ex_taken says.
    always_comb begin
        bus.mispredict = '0;
        n_br           = '0;
        n_mis          = '0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            bus.mispredict[k] = bus.ex_valid[k] &
                                ((bus.ex_taken[k] | bus.ex_is_jump[k]) != bus.ex_pred_taken[k]);
            n_br  = n_br  + INC_W'(bus.ex_valid[k]);
            n_mis = n_mis + INC_W'(bus.mispredict[k]);
        end
    end

    // Slots train in order so same-index updates compose.
    always_comb begin
        bht_d = bht_q;
        for (int k = 0; k < int'(WIDTH); k++) begin
            if (bus.ex_valid[k])
                bht_d[idx(bus.ex_pc[k])] = train(bht_d[idx(bus.ex_pc[k])],
                                                 bus.ex_taken[k], bus.ex_is_jump[k]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(BHT_SIZE); i++)
                bht_q[i] <= WEA_NT;
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            bht_q <= bht_d;
            br_q  <= sat_add(br_q, n_br);
            mis_q <= sat_add(mis_q, n_mis);
        end
    end

    assign bus.br_count      = br_q;
    assign bus.mispred_count = mis_q;
endmodule
